// File: rtl/arg_num_parser_pkg.sv
// arg_num_parser_pkg: ASCII constants, parser states and character classifiers
package arg_num_parser_pkg;
  localparam logic [7:0] CHAR_MINUS = 8'h2D;
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_SEMI  = 8'h3B;
  localparam logic [7:0] CHAR_0     = 8'h30;
  localparam logic [7:0] CHAR_9     = 8'h39;
  typedef enum logic [2:0] {IDLE, FIRST, DIGITS, DRAIN, CHECK, OUT} arg_parse_state_t;
  function automatic logic is_digit(input logic [7:0] c);
    return c >= CHAR_0 && c <= CHAR_9;
  endfunction
  function automatic logic is_terminator(input logic [7:0] c);
    return c == CHAR_SPACE || c == CHAR_LF || c == CHAR_CR || c == CHAR_SEMI;
  endfunction
endpackage

// File: rtl/arg_num_parser_range_check.sv
// arg_range_check: decides whether a sign/magnitude pair fits a signed MAX_ARG_BITS field
module arg_range_check #(
  parameter int MAX_ARG_BITS = 12,
  parameter int NUM_BITS     = 24
) (
  input  logic [NUM_BITS-1:0] mag_i,
  input  logic                neg_i,
  input  logic                ovf_i,
  output logic                fits_o
);
  localparam logic [NUM_BITS-1:0] NEG_MAX = NUM_BITS'(1) << (MAX_ARG_BITS - 1);
  localparam logic [NUM_BITS-1:0] POS_MAX = NEG_MAX - NUM_BITS'(1);
  assign fits_o = !ovf_i && (mag_i <= (neg_i ? NEG_MAX : POS_MAX));
endmodule

// File: rtl/arg_num_parser.sv
// arg_num_parser: serial signed decimal argument parser with range check and valid/ready output
module arg_num_parser
  import arg_num_parser_pkg::*;
#(
  parameter int MAX_ARG_BITS = 12,
  parameter int NUM_BITS     = 2 * MAX_ARG_BITS,
  parameter int MAX_DIGITS   = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [7:0]              char_in,
  input  logic                    char_valid,
  output logic                    char_rdy,
  output logic [MAX_ARG_BITS-1:0] arg,
  output logic                    arg_err,
  output logic                    out_valid,
  input  logic                    out_rdy
);
  localparam int AW = NUM_BITS + 4;
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [NUM_BITS-1:0] ACC_MAX = {1'b0, {(NUM_BITS-1){1'b1}}};
  arg_parse_state_t state_q;
  logic [NUM_BITS-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q;
  logic neg_q, err_bad_q, err_ovf_q, out_valid_q, arg_err_q;
  logic [MAX_ARG_BITS-1:0] arg_q;
  logic [AW-1:0] prod;
  logic accept, ovf_d, fits, res_err;
  assign char_rdy  = state_q inside {FIRST, DIGITS, DRAIN};
  assign accept    = char_valid && char_rdy;
  assign arg       = arg_q;
  assign arg_err   = arg_err_q;
  assign out_valid = out_valid_q;
  assign prod      = AW'(acc_q) * AW'(10) + AW'(char_in - CHAR_0);
  // digit-count overflow keeps cnt bounded; sticky err_ovf carries the error
  assign ovf_d     = prod > AW'(ACC_MAX) || cnt_q == CW'(MAX_DIGITS);
  assign acc_d     = ovf_d ? ACC_MAX : prod[NUM_BITS-1:0];
  assign res_err   = err_bad_q || cnt_q == '0 || !fits;
  arg_range_check #(.MAX_ARG_BITS(MAX_ARG_BITS), .NUM_BITS(NUM_BITS)) u_range (
    .mag_i(acc_q), .neg_i(neg_q), .ovf_i(err_ovf_q), .fits_o(fits)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      err_bad_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      arg_q       <= '0;
      arg_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q   <= FIRST;
          acc_q     <= '0;
          cnt_q     <= '0;
          neg_q     <= 1'b0;
          err_bad_q <= 1'b0;
          err_ovf_q <= 1'b0;
        end
        FIRST, DIGITS: if (accept) begin
          if (is_digit(char_in)) begin
            acc_q     <= acc_d;
            cnt_q     <= ovf_d ? cnt_q : cnt_q + 1'b1;
            err_ovf_q <= err_ovf_q || ovf_d;
            state_q   <= DIGITS;
          end else if (is_terminator(char_in)) begin
            state_q <= CHECK;
          end else if (state_q == FIRST && char_in == CHAR_MINUS) begin
            neg_q   <= 1'b1;
            state_q <= DIGITS;
          end else begin
            err_bad_q <= 1'b1;
            state_q   <= DRAIN;
          end
        end
        DRAIN: if (accept && is_terminator(char_in)) state_q <= CHECK;
        CHECK: begin
          arg_q     <= res_err ? '0 : MAX_ARG_BITS'(neg_q ? -acc_q : acc_q);
          arg_err_q <= res_err;
          state_q   <= OUT;
        end
        OUT: if (!out_valid_q) begin
          out_valid_q <= 1'b1;
        end else if (out_rdy) begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_arg_num_parser.sv
// tb_arg_num_parser: directed strings checked against a string-level parsing model and literals
module tb_arg_num_parser;
  logic clk = 0, rst_n = 0, start = 0, char_valid = 0, out_rdy = 1;
  logic [7:0] char_in = '0;
  logic char_rdy, arg_err, out_valid;
  logic [11:0] arg;
  int errors = 0, checks = 0;
  typedef struct {logic [11:0] a; logic e;} res_t;
  res_t exp_q[$];
  always #5 clk = ~clk;
  arg_num_parser dut (
    .clk(clk), .reset(rst_n), .start(start), .char_in(char_in), .char_valid(char_valid),
    .char_rdy(char_rdy), .arg(arg), .arg_err(arg_err), .out_valid(out_valid), .out_rdy(out_rdy)
  );
  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction
  // parses the whole string as text: optional '-', digits up to a terminator
  function automatic void model(input string s, output logic [11:0] a, output logic e);
    longint v;
    int n, i;
    bit neg, bad, ovf;
    byte c;
    v = 0; n = 0; bad = 0;
    neg = s.len() > 0 && s[0] == 8'h2D;
    for (i = neg ? 1 : 0; i < s.len(); i++) begin
      c = s[i];
      if (c == 8'h20 || c == 8'h0A || c == 8'h0D || c == 8'h3B) break;
      if (c >= 8'h30 && c <= 8'h39 && !bad) begin
        n++;
        v = v * 10 + longint'(c - 8'h30);
      end else bad = 1;
    end
    ovf = n > 6 || v > 64'd8388607;
    e = bad || n == 0 || ovf || (neg ? v > 2048 : v > 2047);
    a = e ? 12'd0 : (neg ? 12'(-v) : 12'(v));
  endfunction
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) chk("unexpected_out_valid", 1, 0);
      else begin
        chk("model_arg", arg, exp_q[0].a);
        chk("model_err", arg_err, exp_q[0].e);
        if (out_rdy) void'(exp_q.pop_front());
      end
    end
  end
  task automatic pulse_start();
    start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("char_rdy_after_start", char_rdy, 1);
  endtask
  task automatic send(input string s, output int stalls);
    bit ok;
    int n;
    stalls = 0;
    for (int i = 0; i < s.len(); i++) begin
      char_in = s[i];
      char_valid = 1;
      ok = 0;
      n = 0;
      while (!ok && n < 20) begin
        @(negedge clk);
        ok = char_rdy;
        @(posedge clk); #1;
        n++;
      end
      if (!ok) chk("char_accept_timeout", 0, 1);
      stalls += n - 1;
    end
    char_valid = 0;
  endtask
  task automatic wait_out(input string name);
    int k;
    k = 0;
    while (!out_valid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    chk({name, "_latency"}, k, 2);
  endtask
  task automatic run(input string name, input string s, input logic [11:0] la, input logic le,
                     output int stalls);
    res_t r;
    model(s, r.a, r.e);
    exp_q.push_back(r);
    pulse_start();
    send(s, stalls);
    wait_out(name);
    chk({name, "_arg"}, arg, la);
    chk({name, "_err"}, arg_err, le);
    @(posedge clk); #1;
    chk({name, "_valid_drop"}, out_valid, 0);
  endtask
  initial begin
    int st;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_char_rdy", char_rdy, 0);
    chk("rst_arg", arg, 0);
    chk("rst_arg_err", arg_err, 0);
    rst_n = 1;
    @(posedge clk); #1;
    run("p2047", "2047 ", 12'h7FF, 0, st);
    run("n2048", "-2048\n", 12'h800, 0, st);
    run("p2048", "2048 ", 12'h000, 1, st);
    run("n2049", "-2049;", 12'h000, 1, st);
    run("neg_zero", "-0 ", 12'h000, 0, st);
    run("ovf8", "99999999 ", 12'h000, 1, st);
    chk("ovf8_no_stall", st, 0);
    run("six_lead0", "000123\r", 12'd123, 0, st);
    run("seven_zeros", "0000000 ", 12'h000, 1, st);
    run("bad_a", "12a3 ", 12'h000, 1, st);
    run("dbl_minus", "--5 ", 12'h000, 1, st);
    run("minus_only", "- ", 12'h000, 1, st);
    run("empty", " ", 12'h000, 1, st);
    out_rdy = 0;
    begin
      res_t r;
      model("100 ", r.a, r.e);
      exp_q.push_back(r);
    end
    pulse_start();
    send("100 ", st);
    wait_out("hold");
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_arg", arg, 100);
      chk("hold_char_rdy", char_rdy, 0);
      start = (i == 2);
      @(posedge clk); #1;
    end
    start = 0;
    out_rdy = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("hold_release_valid", out_valid, 0);
    chk("hold_start_ignored", char_rdy, 0);
    pulse_start();
    send("-12", st);
    rst_n = 0;
    @(posedge clk); #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_char_rdy", char_rdy, 0);
    chk("abort_arg", arg, 0);
    rst_n = 1;
    exp_q.delete();
    run("after_abort", "7 ", 12'd7, 0, st);
    repeat (2) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
